spim_responder: RTL and testbench



---
 rtl/spim_responder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_spim_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spim_responder.sv
`timescale 1ns/1ps
// spim_responder
//   SPI mode-0 responder emulating a 2^ADDR_W byte SRAM for loopback bring-up
//   of the SoC SPI master. SCK, CSn and MOSI are oversampled by clk_i, which
//   must run at 8x SCK or faster.
//
//   Transaction: command byte, address byte, data bytes (MSB first).
//     0x02 WRITE  - each completed byte is stored at addr, addr increments
//     0x03 READ   - mem[addr] is shifted out on MISO, addr increments per byte
//     0x05 RDSR   - only with SPIM_RESP_RDSR_EN defined; returns repeated
//                   {write_count[6:0], err_flag} without an address phase
//     other       - transaction ignored, cmd_err_o pulses
//
//   Configuration macro: SPIM_RESP_RDSR_EN (enables RDSR and its status counters).
//
// Ports
//   clk_i, rst_ni      system clock, asynchronous active-low reset
//   spi_sck_i          SPI clock from master (idle low)
//   spi_csn_i          chip select, active-low
//   spi_mosi_i         master-out data
//   spi_miso_o         slave-out data
//   spi_miso_oe_o      MISO output enable (READ/RDSR data phase only)
//   rx_byte_o          last data byte written by the master
//   rx_valid_o         one-cycle pulse when rx_byte_o updates
//   cmd_err_o          one-cycle pulse on an unknown command
//   busy_o             synchronised CSn is low
module spim_responder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_sck_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       cmd_err_o,
  output logic       busy_o
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [7:0]  CMD_WRITE = 8'h02;
  localparam logic [7:0]  CMD_READ  = 8'h03;
`ifdef SPIM_RESP_RDSR_EN
  localparam logic [7:0]  CMD_RDSR  = 8'h05;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WRITE,
    ST_READ,
    ST_IGNORE,
    ST_RDSR
  } state_e;

  state_e            state_q, state_d;

  // Two synchroniser stages plus one history stage for edge detection.
  logic [2:0]        sck_sync_q, sck_sync_d;
  logic [2:0]        csn_sync_q, csn_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_sr_q, rx_sr_d;
  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_pend_q, wr_pend_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [2:0]        tx_cnt_q, tx_cnt_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              rx_valid_q, rx_valid_d;
  logic              cmd_err_q, cmd_err_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
`ifdef SPIM_RESP_RDSR_EN
  logic [6:0]        write_count_q, write_count_d;
  logic              err_flag_q, err_flag_d;
`endif

  logic              sck_rise, sck_fall, csn_fall, csn_rise;
  logic              tx_active;
  logic [7:0]        rx_full;
  logic [7:0]        tx_byte;

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], spi_sck_i};
    csn_sync_d  = {csn_sync_q[1:0], spi_csn_i};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi_i};

    sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    csn_fall = ~csn_sync_q[1] & csn_sync_q[2];
    csn_rise = csn_sync_q[1] & ~csn_sync_q[2];
    rx_full  = {rx_sr_q, mosi_sync_q[1]};

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    wr_pend_d  = 1'b0;
    wr_data_d  = wr_data_q;
    tx_cnt_d   = tx_cnt_q;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_d      = mem_q;
`ifdef SPIM_RESP_RDSR_EN
    write_count_d = write_count_q;
`endif

    tx_active = (state_q == ST_READ);
`ifdef SPIM_RESP_RDSR_EN
    tx_active = tx_active | (state_q == ST_RDSR);
`endif
    tx_byte = tx_sr_q;

    // A completed write byte is committed one cycle after its last bit, so
    // it survives a CSn rise that arrives right behind it.
    if (wr_pend_q) begin
      mem_d[addr_q] = wr_data_q;
      rx_byte_d     = wr_data_q;
      rx_valid_d    = 1'b1;
      addr_d        = addr_q + ADDR_W'(1);
`ifdef SPIM_RESP_RDSR_EN
      write_count_d = write_count_q + 7'd1;
`endif
    end

    // CSn events take priority; an SCK edge in the same cycle is dropped.
    if (csn_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else if (csn_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else if (sck_rise && (state_q != ST_IDLE)) begin
      rx_sr_d   = rx_full[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        unique case (state_q)
          ST_CMD: begin
            if (rx_full == CMD_WRITE) begin
              state_d   = ST_ADDR;
              is_read_d = 1'b0;
            end else if (rx_full == CMD_READ) begin
              state_d   = ST_ADDR;
              is_read_d = 1'b1;
`ifdef SPIM_RESP_RDSR_EN
            end else if (rx_full == CMD_RDSR) begin
              state_d   = ST_RDSR;
`endif
            end else begin
              state_d   = ST_IGNORE;
              cmd_err_d = 1'b1;
            end
          end
          ST_ADDR: begin
            addr_d  = ADDR_W'(rx_full);
            state_d = is_read_q ? ST_READ : ST_WRITE;
          end
          ST_WRITE: begin
            wr_pend_d = 1'b1;
            wr_data_d = rx_full;
          end
          default: ;
        endcase
      end
    end else if (sck_fall && tx_active) begin
      // The first fall of each output byte loads a fresh byte; the rest shift.
      if (tx_cnt_q == 3'd0) begin
        tx_byte = mem_q[addr_q];
        if (state_q == ST_READ) begin
          addr_d = addr_q + ADDR_W'(1);
        end
`ifdef SPIM_RESP_RDSR_EN
        if (state_q == ST_RDSR) begin
          tx_byte = {write_count_q, err_flag_q};
        end
`endif
      end
      miso_d    = tx_byte[7];
      tx_sr_d   = {tx_byte[6:0], 1'b0};
      miso_oe_d = 1'b1;
      tx_cnt_d  = tx_cnt_q + 3'd1;
    end

`ifdef SPIM_RESP_RDSR_EN
    err_flag_d = err_flag_q | cmd_err_d;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sck_sync_q  <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      is_read_q   <= 1'b0;
      addr_q      <= '0;
      wr_pend_q   <= 1'b0;
      wr_data_q   <= '0;
      tx_cnt_q    <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef SPIM_RESP_RDSR_EN
      write_count_q <= '0;
      err_flag_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      csn_sync_q  <= csn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      is_read_q   <= is_read_d;
      addr_q      <= addr_d;
      wr_pend_q   <= wr_pend_d;
      wr_data_q   <= wr_data_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      cmd_err_q   <= cmd_err_d;
      mem_q       <= mem_d;
`ifdef SPIM_RESP_RDSR_EN
      write_count_q <= write_count_d;
      err_flag_q    <= err_flag_d;
`endif
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = miso_oe_q;
  assign rx_byte_o     = rx_byte_q;
  assign rx_valid_o    = rx_valid_q;
  assign cmd_err_o     = cmd_err_q;
  assign busy_o        = ~csn_sync_q[1];

endmodule

// File: tb/tb_spim_responder.sv
`timescale 1ns/1ps
module tb_spim_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned HALF   = 8;  // clk cycles per SCK half period

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       spi_sck;
  logic       spi_csn;
  logic       spi_mosi;
  logic       spi_miso_o;
  logic       spi_miso_oe_o;
  logic [7:0] rx_byte_o;
  logic       rx_valid_o;
  logic       cmd_err_o;
  logic       busy_o;

  always #5 clk = ~clk;

  spim_responder #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .spi_sck_i    (spi_sck),
    .spi_csn_i    (spi_csn),
    .spi_mosi_i   (spi_mosi),
    .spi_miso_o   (spi_miso_o),
    .spi_miso_oe_o(spi_miso_oe_o),
    .rx_byte_o    (rx_byte_o),
    .rx_valid_o   (rx_valid_o),
    .cmd_err_o    (cmd_err_o),
    .busy_o       (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: cumulative event counts and a log of written bytes.
  int         rx_cnt  = 0;
  int         err_cnt = 0;
  int         oe_cnt  = 0;
  logic [7:0] rx_log [2048];

  always @(negedge clk) begin
    if (rst_ni) begin
      if (rx_valid_o && rx_cnt < 2048) begin
        rx_log[rx_cnt] = rx_byte_o;
        rx_cnt++;
      end
      if (cmd_err_o) err_cnt++;
      if (spi_miso_oe_o) oe_cnt++;
    end
  end

  // Reference model: memory image plus status counters.
  logic [7:0] ref_mem [DEPTH];
  logic [6:0] ref_wcount;
  logic       ref_eflag;

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
    ref_wcount = '0;
    ref_eflag  = 1'b0;
  endtask

  logic [7:0] tx_buf [16];
  logic [7:0] rx_buf [16];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: data set while SCK low, MISO sampled just before the rise.
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clk(HALF);
    m = spi_miso_o;
    spi_sck = 1'b1;
    wait_clk(HALF);
    spi_sck = 1'b0;
  endtask

  task automatic spi_run(input int nbits);
    logic m;
    for (int i = 0; i < 16; i++) rx_buf[i] = 8'h00;
    spi_csn = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(tx_buf[i/8][7-(i%8)], m);
      rx_buf[i/8][7-(i%8)] = m;
    end
    wait_clk(HALF);
    spi_csn = 1'b1;
    wait_clk(2*HALF);
  endtask

  // Run one transaction of nbits and check every observable against the model.
  task automatic do_txn(input int nbits);
    int         rx0, err0, oe0, nb, nwr, exp_err;
    logic [7:0] cmd, a, idx;
    logic [7:0] exp_rx [16];
    logic       drives;
    rx0 = rx_cnt; err0 = err_cnt; oe0 = oe_cnt;
    spi_run(nbits);
    nb = nbits / 8; nwr = 0; exp_err = 0; drives = 1'b0;
    cmd = tx_buf[0]; a = tx_buf[1];
    if (nb >= 1) begin
      if (cmd == 8'h02) begin
        for (int j = 0; j < nb - 2; j++) begin
          idx = a + 8'(j);
          ref_mem[idx] = tx_buf[2+j];
          exp_rx[nwr] = tx_buf[2+j];
          nwr++;
          ref_wcount = ref_wcount + 7'd1;
        end
      end else if (cmd == 8'h03) begin
        drives = 1'b1;
        for (int j = 0; j < nb - 2; j++) begin
          idx = a + 8'(j);
          check("read_data", int'(rx_buf[2+j]), int'(ref_mem[idx]));
        end
`ifdef SPIM_RESP_RDSR_EN
      end else if (cmd == 8'h05) begin
        drives = 1'b1;
        for (int j = 0; j < nb - 1; j++)
          check("rdsr_data", int'(rx_buf[1+j]), int'({ref_wcount, ref_eflag}));
`endif
      end else begin
        exp_err = 1;
        ref_eflag = 1'b1;
      end
    end
    check("cmd_err_pulses", err_cnt - err0, exp_err);
    check("rx_valid_pulses", rx_cnt - rx0, nwr);
    for (int j = 0; j < nwr && j < 16; j++)
      check("rx_byte", int'(rx_log[rx0+j]), int'(exp_rx[j]));
    if (!drives) check("oe_idle", oe_cnt - oe0, 0);
  endtask

  initial begin
    #5ms;
    errors++;
    $display("FAIL timeout simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic m;
    int   sel, nb, nbits;
    rst_ni = 1'b0; spi_csn = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    model_reset();
    wait_clk(3);
    check("rst_miso", int'(spi_miso_o), 0);
    check("rst_oe", int'(spi_miso_oe_o), 0);
    check("rst_rx_byte", int'(rx_byte_o), 0);
    check("rst_rx_valid", int'(rx_valid_o), 0);
    check("rst_cmd_err", int'(cmd_err_o), 0);
    check("rst_busy", int'(busy_o), 0);
    rst_ni = 1'b1;
    wait_clk(5);

    // Write two bytes then read them back.
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h10; tx_buf[2] = 8'hA5; tx_buf[3] = 8'h3C;
    do_txn(32);
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h10; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    do_txn(32);
    check("read_a5", int'(rx_buf[2]), 8'hA5);
    check("read_3c", int'(rx_buf[3]), 8'h3C);

    // Address wrap at the top of memory.
    tx_buf[0] = 8'h02; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22;
    do_txn(32);
    tx_buf[0] = 8'h03; tx_buf[1] = 8'hFF;
    do_txn(32);
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h00;
    do_txn(24);
    check("wrap_mem0", int'(rx_buf[2]), 8'h22);

    // Unknown command.
    tx_buf[0] = 8'h9F; tx_buf[1] = 8'h10; tx_buf[2] = 8'h55;
    do_txn(24);

    // Aborted write after 5 data bits.
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h20; tx_buf[2] = 8'hFF;
    do_txn(21);
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h20;
    do_txn(24);
    check("abort_mem20", int'(rx_buf[2]), 8'h00);

    // Reset asserted in the data phase of a read.
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h10; tx_buf[2] = 8'h00;
    spi_csn = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 20; i++) spi_bit(tx_buf[i/8][7-(i%8)], m);
    check("mid_busy", int'(busy_o), 1);
    check("mid_oe", int'(spi_miso_oe_o), 1);
    rst_ni = 1'b0;
    #1;
    check("arst_oe", int'(spi_miso_oe_o), 0);
    check("arst_busy", int'(busy_o), 0);
    check("arst_miso", int'(spi_miso_o), 0);
    spi_csn = 1'b1; spi_sck = 1'b0;
    wait_clk(4);
    rst_ni = 1'b1;
    model_reset();
    wait_clk(4);
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h10;
    do_txn(24);
    check("arst_mem10", int'(rx_buf[2]), 8'h00);

    // Status read after three writes and one bad command.
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h40;
    tx_buf[2] = 8'h01; tx_buf[3] = 8'h02; tx_buf[4] = 8'h03;
    do_txn(40);
    tx_buf[0] = 8'hC7;
    do_txn(8);
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    do_txn(24);
`ifdef SPIM_RESP_RDSR_EN
    check("rdsr_07", int'(rx_buf[1]), 8'h07);
`endif

    // Randomized transactions, including truncated ones.
    for (int t = 0; t < 30; t++) begin
      sel = int'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) tx_buf[i] = 8'($urandom);
      case (sel)
        0: tx_buf[0] = 8'h02;
        1: tx_buf[0] = 8'h03;
        2: tx_buf[0] = 8'h05;
        default: ;
      endcase
      nb = int'($urandom_range(0, 5));
      nbits = 8 * nb;
      if ($urandom_range(0, 3) == 0) nbits = nbits + int'($urandom_range(1, 7));
      do_txn(nbits);
    end

    // Final sweep of a few written locations.
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h40;
    do_txn(48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
